level_crossing_sequencer: RTL and testbench
===========================================

// Module: level_crossing_sequencer
// PURPOSE
//   Sequences one level-crossing gate shared by two tracks (track 0, track 1).
//   Counts trains per track from approach/exit pulses, and drives warning lamp
//   and gate motor through warn -> lower -> hold -> raise.
//   Monitors gate limit switches and latches a sticky fault.
//   Sits between debounced track sensors and the gate motor driver.
// PARAMETERS
//   WARN_CYC  10  cycles warn_led is lit before gate_dn asserts
//   MOVE_TMO   8  max cycles in LOWER/RAISE without limit-switch confirm
//   HOLD_CYC   2  consecutive all-clear cycles in CLOSED before raising
//   TMR_W      8  shared timer width; must hold max(WARN_CYC,MOVE_TMO,HOLD_CYC)
// PORTS
//   clk            in   1  system clock
//   reset          in   1  synchronous, active-high reset
//   appr[1:0]      in   2  per-track approach pulse, 1 cycle, pre-synchronised
//   exit[1:0]      in   2  per-track exit pulse, 1 cycle, pre-synchronised
//   gate_closed_fb in   1  gate-down limit switch
//   gate_open_fb   in   1  gate-up limit switch
//   warn_led       out  1  warning lamp/buzzer
//   gate_dn        out  1  motor drive, lower
//   gate_up        out  1  motor drive, raise
//   fault          out  1  sticky fault flag
//   occ0, occ1     out  2  track 0/1 train occupancy count
//   state          out  3  current FSM state (debug)
// BEHAVIOUR
//   Reset: state=IDLE, timer=0, occ0=occ1=0, all outputs 0. Reset in any
//   state (incl. FAULT, mid-LOWER) takes effect at the next clk edge.
//   Occupancy, per track, 2-bit:
//   - appr only -> +1, saturating at 3.
//   - exit only -> -1; exit at 0 is ignored.
//   - appr and exit in the same cycle -> unchanged.
//   "busy" = (occ0|occ1 != 0) | (|appr); this includes same-cycle pulses.
//   States (encoding 0..5). Outputs are Moore-decoded from registered state.
//   Timer clears on every state change.
//   - IDLE(0): all outputs 0. busy -> WARN.
//     warn_led is high on the cycle after the appr pulse.
//   - WARN(1): warn_led=1. Lasts exactly WARN_CYC cycles, then LOWER.
//     Extra approaches do not restart the timer.
//   - LOWER(2): warn_led=1, gate_dn=1.
//     gate_closed_fb sampled high -> CLOSED.
//     Else timer reaches MOVE_TMO cycles -> FAULT.
//   - CLOSED(3): warn_led=1, motors off. Timer counts consecutive !busy cycles.
//     Any busy cycle clears it. Timer reaches HOLD_CYC -> RAISE.
//   - RAISE(4): warn_led=1, gate_up=1. Checks in priority order:
//     busy -> LOWER next cycle (gate_up drops, gate_dn rises in same cycle);
//     else gate_open_fb -> IDLE;
//     else MOVE_TMO cycles elapsed -> FAULT.
//   - FAULT(5): fault=1, warn_led=1, gate_dn=gate_up=0.
//     Exits only on reset. Occupancy keeps counting.
//   Both limit switches high in the same cycle, in any state but FAULT
//   -> FAULT next cycle. This overrides all other transitions.
//   gate_dn and gate_up are never both 1.
// TESTING
//   1 Single train:
//     appr[0] @c0 -> warn_led=1 c1..c10; gate_dn=1 from c11.
//     closed_fb @c13 -> CLOSED, gate_dn=0.
//     exit[0] -> 2 clear cycles -> gate_up=1.
//     open_fb -> IDLE, all outputs 0.
//   2 Two tracks overlap: appr0, appr1, exit0, with gate in CLOSED
//     -> gate stays down (occ1=1). exit1 -> RAISE after 2 clear cycles.
//   3 appr[1] during RAISE -> gate_up=0, gate_dn=1 next cycle; state=LOWER.
//   4 No closed_fb -> fault=1 after 8 cycles in LOWER.
//     Fault holds through further appr/fb activity. Reset clears fault, occ, outputs.
//   5 Occupancy boundaries:
//     - appr0 and exit0 in the same cycle -> occ0 unchanged.
//     - exit0 at occ0=0 -> stays 0.
//     - 4 appr0 pulses -> occ0=3.
//   6 Both fb high in CLOSED -> FAULT. Reset asserted mid-LOWER -> IDLE next cycle.

Source files
------------

// File: rtl/level_crossing_sequencer.sv
// Level-crossing gate sequencer for two tracks: per-track train occupancy,
// warn/lower/hold/raise gate sequencing, and a sticky fault on limit-switch errors.
module level_crossing_sequencer #(
    parameter int unsigned WARN_CYC = 10,
    parameter int unsigned MOVE_TMO = 8,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned TMR_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] appr,
    input  logic [1:0] exit,
    input  logic       gate_closed_fb,
    input  logic       gate_open_fb,
    output logic       warn_led,
    output logic       gate_dn,
    output logic       gate_up,
    output logic       fault,
    output logic [1:0] occ0,
    output logic [1:0] occ1,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARN   = 3'd1,
        ST_LOWER  = 3'd2,
        ST_CLOSED = 3'd3,
        ST_RAISE  = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam logic [TMR_W-1:0] WARN_LAST = TMR_W'(WARN_CYC - 1);
    localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_TMO - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       occ0_q, occ0_d;
    logic [1:0]       occ1_q, occ1_d;
    logic [TMR_W-1:0] timer_cnt;
    logic             busy;
    logic             both_fb;

    // Saturating up on approach, floor at zero on exit, hold when both or neither.
    function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                            input logic       a,
                                            input logic       e);
        logic [1:0] r;
        r = occ;
        if (a && !e && occ != 2'd3) r = occ + 2'd1;
        if (!a && e && occ != 2'd0) r = occ - 2'd1;
        return r;
    endfunction

    always_comb begin
        occ0_d = occ_next(occ0_q, appr[0], exit[0]);
        occ1_d = occ_next(occ1_q, appr[1], exit[1]);
    end

    assign busy    = (occ0_q != 2'd0) || (occ1_q != 2'd0) || (|appr);
    assign both_fb = gate_closed_fb && gate_open_fb;

    always_comb begin
        state_d   = state_q;
        timer_cnt = timer_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                timer_cnt = '0;
                if (busy) state_d = ST_WARN;
            end
            ST_WARN: begin
                if (timer_q == WARN_LAST) state_d = ST_LOWER;
            end
            ST_LOWER: begin
                if (gate_closed_fb)            state_d = ST_CLOSED;
                else if (timer_q == MOVE_LAST) state_d = ST_FAULT;
            end
            ST_CLOSED: begin
                // Timer here counts only consecutive clear cycles.
                if (busy)                      timer_cnt = '0;
                else if (timer_q == HOLD_LAST) state_d = ST_RAISE;
            end
            ST_RAISE: begin
                if (busy)                      state_d = ST_LOWER;
                else if (gate_open_fb)         state_d = ST_IDLE;
                else if (timer_q == MOVE_LAST) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                timer_cnt = timer_q;
            end
            default: begin
                state_d   = ST_FAULT;
                timer_cnt = '0;
            end
        endcase

        if (both_fb && state_q != ST_FAULT) state_d = ST_FAULT;

        timer_d = (state_d != state_q) ? '0 : timer_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            occ0_q  <= '0;
            occ1_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            occ0_q  <= occ0_d;
            occ1_q  <= occ1_d;
        end
    end

    always_comb begin
        warn_led = 1'b0;
        gate_dn  = 1'b0;
        gate_up  = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            ST_IDLE:   ;
            ST_WARN:   warn_led = 1'b1;
            ST_LOWER:  begin warn_led = 1'b1; gate_dn = 1'b1; end
            ST_CLOSED: warn_led = 1'b1;
            ST_RAISE:  begin warn_led = 1'b1; gate_up = 1'b1; end
            ST_FAULT:  begin warn_led = 1'b1; fault = 1'b1; end
            default:   begin warn_led = 1'b1; fault = 1'b1; end
        endcase
    end

    assign occ0  = occ0_q;
    assign occ1  = occ1_q;
    assign state = state_q;

endmodule

// File: tb/tb_level_crossing_sequencer.sv
// Directed bench for level_crossing_sequencer; expected values hand-derived
// from the cycle timeline of each scenario.
module tb_level_crossing_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] appr;
    logic [1:0] exit_p;
    logic       closed_fb;
    logic       open_fb;
    logic       warn_led;
    logic       gate_dn;
    logic       gate_up;
    logic       fault;
    logic [1:0] occ0;
    logic [1:0] occ1;
    logic [2:0] state;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    level_crossing_sequencer #(
        .WARN_CYC(10),
        .MOVE_TMO(8),
        .HOLD_CYC(2),
        .TMR_W   (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .appr          (appr),
        .exit          (exit_p),
        .gate_closed_fb(closed_fb),
        .gate_open_fb  (open_fb),
        .warn_led      (warn_led),
        .gate_dn       (gate_dn),
        .gate_up       (gate_up),
        .fault         (fault),
        .occ0          (occ0),
        .occ1          (occ1),
        .state         (state)
    );

    always #5 clk = ~clk;

    // {state, warn_led, gate_dn, gate_up, fault}
    logic [6:0] outs;
    assign outs = {state, warn_led, gate_dn, gate_up, fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; pulse inputs last exactly one sampled edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            appr   = '0;
            exit_p = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        appr      = '0;
        exit_p    = '0;
        closed_fb = 1'b0;
        open_fb   = 1'b0;
        step(2);
        chk("reset_outs", 32'(outs), 32'({3'd0, 4'b0000}));
        chk("reset_occ",  32'({occ1, occ0}), 32'd0);
        reset = 1'b0;

        // Single train
        appr = 2'b01; step();
        chk("t1_warn_c1", 32'(outs), 32'({3'd1, 4'b1000}));
        chk("t1_occ0",    32'(occ0), 32'd1);
        step(9);
        chk("t1_warn_c10", 32'(outs), 32'({3'd1, 4'b1000}));
        step();
        chk("t1_lower_c11", 32'(outs), 32'({3'd2, 4'b1100}));
        step(2);
        chk("t1_lower_c13", 32'(outs), 32'({3'd2, 4'b1100}));
        closed_fb = 1'b1; step();
        chk("t1_closed", 32'(outs), 32'({3'd3, 4'b1000}));
        closed_fb = 1'b0;
        exit_p = 2'b01; step();
        chk("t1_occ0_exit", 32'(occ0), 32'd0);
        chk("t1_hold1", 32'(outs), 32'({3'd3, 4'b1000}));
        step();
        chk("t1_hold2", 32'(outs), 32'({3'd3, 4'b1000}));
        step();
        chk("t1_raise", 32'(outs), 32'({3'd4, 4'b1010}));
        open_fb = 1'b1; step();
        chk("t1_idle", 32'(outs), 32'({3'd0, 4'b0000}));
        open_fb = 1'b0;

        // Two tracks overlap
        appr = 2'b01; step();
        appr = 2'b10; step();
        step(9);
        chk("t2_lower", 32'(outs), 32'({3'd2, 4'b1100}));
        chk("t2_occ",   32'({occ1, occ0}), 32'({2'd1, 2'd1}));
        closed_fb = 1'b1; step();
        closed_fb = 1'b0;
        exit_p = 2'b01; step();
        chk("t2_occ_after_exit0", 32'({occ1, occ0}), 32'({2'd1, 2'd0}));
        step(4);
        chk("t2_stays_closed", 32'(outs), 32'({3'd3, 4'b1000}));
        exit_p = 2'b10; step();
        step();
        chk("t2_hold", 32'(outs), 32'({3'd3, 4'b1000}));
        step();
        chk("t2_raise", 32'(outs), 32'({3'd4, 4'b1010}));

        // Approach during RAISE re-lowers
        appr = 2'b10; step();
        chk("t3_relower", 32'(outs), 32'({3'd2, 4'b1100}));
        chk("t3_occ1",    32'(occ1), 32'd1);

        // Lower timeout
        step(7);
        chk("t4_lower_last", 32'(outs), 32'({3'd2, 4'b1100}));
        step();
        chk("t4_fault", 32'(outs), 32'({3'd5, 4'b1001}));
        appr = 2'b01; closed_fb = 1'b1; open_fb = 1'b1; step();
        chk("t4_fault_sticky", 32'(outs), 32'({3'd5, 4'b1001}));
        chk("t4_occ_counts",   32'({occ1, occ0}), 32'({2'd1, 2'd1}));
        closed_fb = 1'b0; open_fb = 1'b0;
        step(3);
        chk("t4_fault_hold", 32'(outs), 32'({3'd5, 4'b1001}));
        reset = 1'b1; step(); reset = 1'b0;
        chk("t4_reset_outs", 32'(outs), 32'({3'd0, 4'b0000}));
        chk("t4_reset_occ",  32'({occ1, occ0}), 32'd0);

        // Occupancy boundaries
        appr = 2'b01; exit_p = 2'b01; step();
        chk("t5_same_cycle", 32'(occ0), 32'd0);
        exit_p = 2'b01; step();
        chk("t5_exit_at_0", 32'(occ0), 32'd0);
        appr = 2'b01; step();
        appr = 2'b01; step();
        appr = 2'b01; step();
        chk("t5_occ3", 32'(occ0), 32'd3);
        appr = 2'b01; step();
        chk("t5_saturate", 32'(occ0), 32'd3);
        appr = 2'b01; exit_p = 2'b01; step();
        chk("t5_same_at_3", 32'(occ0), 32'd3);
        exit_p = 2'b01; step();
        chk("t5_dec", 32'(occ0), 32'd2);
        reset = 1'b1; step(); reset = 1'b0;

        // Both limit switches in CLOSED
        appr = 2'b01; step();
        step(10);
        closed_fb = 1'b1; step();
        chk("t6_closed", 32'(outs), 32'({3'd3, 4'b1000}));
        open_fb = 1'b1; step();
        chk("t6_both_fb_fault", 32'(outs), 32'({3'd5, 4'b1001}));
        closed_fb = 1'b0; open_fb = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_reset_from_fault", 32'(outs), 32'({3'd0, 4'b0000}));

        // Reset mid-LOWER
        appr = 2'b01; step();
        step(10);
        step(2);
        chk("t6_mid_lower", 32'(outs), 32'({3'd2, 4'b1100}));
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_reset_mid_lower", 32'(outs), 32'({3'd0, 4'b0000}));
        chk("t6_reset_occ", 32'({occ1, occ0}), 32'd0);
        step(2);
        chk("t6_idle_after", 32'(outs), 32'({3'd0, 4'b0000}));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
